rgb_fade_ramp: RTL and testbench

- Sits between the key-driven RGB level registers and the three LED_PWM channel instances.
- Takes per-channel target brightness levels and produces current levels that step one unit at a time toward the targets, at a fixed tick rate, so a key press becomes a smooth fade.
- Current levels drive LED_PWM led_pwm inputs directly and also feed the 7-segment digit split.

---
 rtl/rgb_fade_ramp.sv | 156 +++++++++++++++
 tb/tb_rgb_fade_ramp.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_fade_ramp.sv
// Smooth per-channel fade of RGB levels toward key-driven targets.
// Each channel steps one unit per STEP_CYCLES clocks; snap jumps straight to the targets.

module rgb_fade_chan #(
    parameter int MAX_LEVEL   = 25,
    parameter int RESET_LEVEL = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] target_i,
    input  logic       load_i,
    input  logic       step_i,
    output logic [7:0] cur_o,
    output logic       eq_o,
    output logic       eq_step_o
);
    localparam logic [7:0] MAX_L = 8'(MAX_LEVEL);
    localparam logic [7:0] RST_L = 8'(RESET_LEVEL);

    logic [7:0] tgt;
    logic [7:0] step_val;
    logic [7:0] cur_q, cur_d;

    assign tgt = (target_i > MAX_L) ? MAX_L : target_i;

    // cur never leaves 0..MAX_LEVEL, so the +/-1 cannot wrap
    always_comb begin
        step_val = cur_q;
        if (cur_q < tgt)
            step_val = cur_q + 8'd1;
        else if (cur_q > tgt)
            step_val = cur_q - 8'd1;
    end

    always_comb begin
        cur_d = cur_q;
        if (load_i)
            cur_d = tgt;
        else if (step_i)
            cur_d = step_val;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cur_q <= RST_L;
        else
            cur_q <= cur_d;
    end

    assign cur_o     = cur_q;
    assign eq_o      = (cur_q == tgt);
    assign eq_step_o = (step_val == tgt);
endmodule

module rgb_fade_ramp #(
    parameter int STEP_CYCLES = 500000,
    parameter int MAX_LEVEL   = 25,
    parameter int RESET_LEVEL = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] target_r,
    input  logic [7:0] target_g,
    input  logic [7:0] target_b,
    input  logic       snap,
    output logic [7:0] cur_r,
    output logic [7:0] cur_g,
    output logic [7:0] cur_b,
    output logic       busy,
    output logic       settled_pulse
);
    localparam int          NUM_CH = 3;
    localparam int          CW     = $clog2(STEP_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

    typedef enum logic {IDLE, RAMP} state_e;

    state_e                       state_q, state_d;
    logic [CW-1:0]                count_q, count_d;
    logic                         busy_q, busy_d;
    logic                         settled_q, settled_d;
    logic                         tick, match, match_step;
    logic                         load, step_en;
    logic [NUM_CH-1:0][7:0]       target, cur;
    logic [NUM_CH-1:0]            eq, eq_step;

    assign target = {target_b, target_g, target_r};

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        rgb_fade_chan #(
            .MAX_LEVEL  (MAX_LEVEL),
            .RESET_LEVEL(RESET_LEVEL)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .target_i (target[c]),
            .load_i   (load),
            .step_i   (step_en),
            .cur_o    (cur[c]),
            .eq_o     (eq[c]),
            .eq_step_o(eq_step[c])
        );
    end

    assign match      = &eq;
    assign match_step = &eq_step;
    assign tick       = (state_q == RAMP) && (count_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            busy_q    <= 1'b0;
            settled_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            settled_q <= settled_d;
        end
    end

    // Retargeting mid-ramp does not restart the counter; it only changes where the next tick steps.
    always_comb begin
        state_d = state_q;
        count_d = '0;
        case (state_q)
            IDLE: begin
                if (!snap && !match)
                    state_d = RAMP;
            end
            RAMP: begin
                if (snap || match)
                    state_d = IDLE;
                else if (tick && match_step)
                    state_d = IDLE;
                else
                    count_d = tick ? '0 : count_q + CW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load      = snap;
        step_en   = (state_q == RAMP) && !snap && !match && tick;
        busy_d    = (state_d == RAMP);
        settled_d = (state_q == RAMP) && (state_d == IDLE);
    end

    assign cur_r         = cur[0];
    assign cur_g         = cur[1];
    assign cur_b         = cur[2];
    assign busy          = busy_q;
    assign settled_pulse = settled_q;
endmodule

// File: tb/tb_rgb_fade_ramp.sv
// Bench for rgb_fade_ramp: directed scenarios plus a randomized run against a
// timestamp-based reference model of the fade behaviour.

module tb_rgb_fade_ramp;
    localparam int STEP = 4;
    localparam int MAXL = 25;
    localparam int RSTL = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] target_r, target_g, target_b;
    logic       snap;
    logic [7:0] cur_r, cur_g, cur_b;
    logic       busy, settled_pulse;

    int n_tests = 0;
    int n_fail  = 0;

    // model: current levels, ramping flag, absolute cycle of the next step
    int m_cur[3];
    bit m_ramp;
    bit m_settle;
    int m_next;
    int cyc = 0;

    rgb_fade_ramp #(.STEP_CYCLES(STEP), .MAX_LEVEL(MAXL), .RESET_LEVEL(RSTL)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .target_r     (target_r),
        .target_g     (target_g),
        .target_b     (target_b),
        .snap         (snap),
        .cur_r        (cur_r),
        .cur_g        (cur_g),
        .cur_b        (cur_b),
        .busy         (busy),
        .settled_pulse(settled_pulse)
    );

    always #5 clk = ~clk;

    function automatic int clampv(input logic [7:0] v);
        return (int'(v) > MAXL) ? MAXL : int'(v);
    endfunction

    function automatic logic [25:0] exp_vec();
        return {8'(m_cur[0]), 8'(m_cur[1]), 8'(m_cur[2]), m_ramp, m_settle};
    endfunction

    function automatic logic [25:0] dut_vec();
        return {cur_r, cur_g, cur_b, busy, settled_pulse};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_cur[i] = RSTL;
        m_ramp   = 0;
        m_settle = 0;
    endtask

    task automatic model_edge();
        int  tg[3];
        bit  all_eq;
        cyc++;
        tg[0] = clampv(target_r);
        tg[1] = clampv(target_g);
        tg[2] = clampv(target_b);
        all_eq = (m_cur[0] == tg[0]) && (m_cur[1] == tg[1]) && (m_cur[2] == tg[2]);
        m_settle = 0;
        if (!m_ramp) begin
            if (snap) begin
                for (int i = 0; i < 3; i++) m_cur[i] = tg[i];
            end else if (!all_eq) begin
                m_ramp = 1;
                m_next = cyc + STEP;
            end
        end else if (snap) begin
            for (int i = 0; i < 3; i++) m_cur[i] = tg[i];
            m_ramp = 0; m_settle = 1;
        end else if (all_eq) begin
            m_ramp = 0; m_settle = 1;
        end else if (cyc == m_next) begin
            for (int i = 0; i < 3; i++)
                m_cur[i] += (m_cur[i] < tg[i]) ? 1 : (m_cur[i] > tg[i]) ? -1 : 0;
            m_next = cyc + STEP;
            if (m_cur[0] == tg[0] && m_cur[1] == tg[1] && m_cur[2] == tg[2]) begin
                m_ramp = 0; m_settle = 1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; snap = 1'b0;
        target_r = 8'd1; target_g = 8'd1; target_b = 8'd1;
        model_reset();
        repeat (2) step();
        n_tests++;
        if (dut_vec() !== {8'd1, 8'd1, 8'd1, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL reset_state got=%h want=%h", dut_vec(), {8'd1, 8'd1, 8'd1, 2'b00});
        end
        rst_n = 1'b1;
        for (int k = 0; k < 50; k++) begin
            step();
            n_tests++;
            if (dut_vec() !== {8'd1, 8'd1, 8'd1, 1'b0, 1'b0}) begin
                n_fail++; $display("FAIL reset_hold cyc=%0d got=%h want=%h", k, dut_vec(), {8'd1, 8'd1, 8'd1, 2'b00});
            end
        end
    endtask

    task automatic test_single_ramp();
        int er;
        target_r = 8'd5;
        for (int k = 1; k <= 20; k++) begin
            step();
            er = 1 + (k - 1) / STEP;
            if (er > 5) er = 5;
            n_tests++;
            if (cur_r !== 8'(er) || busy !== (k <= 16) || settled_pulse !== (k == 17)) begin
                n_fail++;
                $display("FAIL single_ramp k=%0d got r=%0d busy=%b sp=%b want r=%0d busy=%b sp=%b",
                         k, cur_r, busy, settled_pulse, er, (k <= 16), (k == 17));
            end
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL single_ramp_model k=%0d got=%h want=%h", k, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_two_channel();
        int pulses = 0;
        target_r = 8'd3; target_g = 8'd4;
        for (int k = 1; k <= 18; k++) begin
            step();
            pulses += settled_pulse;
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL two_chan_model k=%0d got=%h want=%h", k, dut_vec(), exp_vec());
            end
            if (k == 13) begin
                n_tests++;
                if (cur_r !== 8'd3 || cur_g !== 8'd4 || settled_pulse !== 1'b1) begin
                    n_fail++; $display("FAIL two_chan_final got r=%0d g=%0d sp=%b want r=3 g=4 sp=1",
                                       cur_r, cur_g, settled_pulse);
                end
            end
        end
        n_tests++;
        if (pulses != 1) begin
            n_fail++; $display("FAIL two_chan_pulses got=%0d want=1", pulses);
        end
    endtask

    task automatic test_clamp();
        int pulses = 0;
        target_b = 8'd200;
        for (int k = 1; k <= 110; k++) begin
            step();
            pulses += settled_pulse;
            n_tests++;
            if (dut_vec() !== exp_vec() || cur_b > 8'd25) begin
                n_fail++; $display("FAIL clamp_model k=%0d got=%h want=%h", k, dut_vec(), exp_vec());
            end
        end
        n_tests++;
        if (cur_b !== 8'd25 || pulses != 1) begin
            n_fail++; $display("FAIL clamp_final got b=%0d pulses=%0d want b=25 pulses=1", cur_b, pulses);
        end
    endtask

    task automatic test_retarget();
        int seq[$];
        int prev;
        bit hit = 0;
        target_r = 8'd10;
        for (int k = 0; k < 40 && !hit; k++) begin
            step();
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL retarget_up k=%0d got=%h want=%h", k, dut_vec(), exp_vec());
            end
            hit = (cur_r == 8'd4);
        end
        n_tests++;
        if (!hit) begin
            n_fail++; $display("FAIL retarget_wait got r=%0d want 4 within 40 cycles", cur_r);
        end
        target_r = 8'd2;
        prev = int'(cur_r);
        for (int k = 0; k < 20; k++) begin
            step();
            if (int'(cur_r) != prev) begin seq.push_back(int'(cur_r)); prev = int'(cur_r); end
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL retarget_down k=%0d got=%h want=%h", k, dut_vec(), exp_vec());
            end
        end
        n_tests++;
        if (seq.size() != 2 || seq[0] != 3 || seq[1] != 2) begin
            n_fail++; $display("FAIL retarget_seq got size=%0d r=%0d want 3 then 2", seq.size(), cur_r);
        end
        // snap in the middle of a ramp
        target_r = 8'd10;
        repeat (6) step();
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL snap_pre_busy got=%b want=1", busy);
        end
        target_g = 8'd20; snap = 1'b1;
        step();
        snap = 1'b0;
        n_tests++;
        if (cur_g !== 8'd20 || busy !== 1'b0 || settled_pulse !== 1'b1 || dut_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL snap_load got g=%0d busy=%b sp=%b want g=20 busy=0 sp=1",
                               cur_g, busy, settled_pulse);
        end
        step();
        n_tests++;
        if (settled_pulse !== 1'b0 || dut_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL snap_after got=%h want=%h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_reset_midramp();
        bit hit = 0;
        target_r = 8'd3; snap = 1'b1;
        step();
        snap = 1'b0;
        target_r = 8'd12;
        for (int k = 0; k < 40 && !hit; k++) begin
            step();
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL midreset_ramp k=%0d got=%h want=%h", k, dut_vec(), exp_vec());
            end
            hit = (cur_r == 8'd7);
        end
        n_tests++;
        if (!hit) begin
            n_fail++; $display("FAIL midreset_wait got r=%0d want 7 within 40 cycles", cur_r);
        end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        n_tests++;
        if (cur_r !== 8'd1 || busy !== 1'b0 || settled_pulse !== 1'b0) begin
            n_fail++; $display("FAIL async_reset got r=%0d busy=%b sp=%b want r=1 busy=0 sp=0",
                               cur_r, busy, settled_pulse);
        end
        @(negedge clk);
        target_r = 8'd7; target_g = 8'd1; target_b = 8'd1;
        rst_n = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            step();
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL restart_model k=%0d got=%h want=%h", k, dut_vec(), exp_vec());
            end
            if (k == 5) begin
                n_tests++;
                if (cur_r !== 8'd2 || busy !== 1'b1) begin
                    n_fail++; $display("FAIL restart_first got r=%0d busy=%b want r=2 busy=1", cur_r, busy);
                end
            end
        end
    endtask

    task automatic test_random();
        bit prev_sp = 0;
        logic [7:0] v;
        for (int k = 0; k < 600; k++) begin
            if ($urandom % 8 == 0) begin
                v = ($urandom % 4 == 0) ? 8'($urandom_range(26, 255)) : 8'($urandom_range(0, 25));
                case ($urandom % 3)
                    0: target_r = v;
                    1: target_g = v;
                    default: target_b = v;
                endcase
            end
            snap = ($urandom % 40 == 0);
            step();
            snap = 1'b0;
            n_tests++;
            if (dut_vec() !== exp_vec() || (prev_sp && settled_pulse)) begin
                n_fail++; $display("FAIL random k=%0d got=%h want=%h", k, dut_vec(), exp_vec());
            end
            prev_sp = settled_pulse;
        end
    endtask

    initial begin
        test_reset();
        test_single_ramp();
        test_two_channel();
        test_clamp();
        test_retarget();
        test_reset_midramp();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
